// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and helpers for the CNN datapath blocks.
//   POOL_MIN/POOL_MAX   legal pooling window/stride range
//   SEQ_LEN_MAX         largest frame length (vectors per frame)
//   cnt_w()             bit width of a counter that runs 0..n-1
package cnn_pkg;

  localparam int POOL_MIN    = 2;
  localparam int POOL_MAX    = 16;
  localparam int SEQ_LEN_MAX = 65535;

  // Width of a counter spanning 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/max_lane.sv
// max_lane: one channel of the max-pooling datapath.
// Holds the running-max accumulator and the registered output sample.
//   clk      clock
//   rst_n    asynchronous active-low reset (clears acc and output)
//   en_i     a valid sample is presented this cycle
//   first_i  sample opens a new window: load instead of compare
//   close_i  sample closes the window: publish the max to data_o
//   data_i   signed input sample
//   data_o   pooled sample, held until the next close
module max_lane #(
  parameter int BW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          first_i,
  input  logic          close_i,
  input  logic [BW-1:0] data_i,
  output logic [BW-1:0] data_o
);

  logic [BW-1:0] acc_q, acc_d;
  logic [BW-1:0] out_q;

  // Strict greater-than, so ties keep the stored value.
  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      if (first_i || ($signed(data_i) > $signed(acc_q))) begin
        acc_d = data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      // The closing sample is already folded into acc_d, so the output
      // register sees the full window max in the same edge.
      if (en_i && close_i) begin
        out_q <= acc_d;
      end
    end
  end

  assign data_o = out_q;

endmodule

// File: rtl/maxpool_fp.sv
// maxpool_fp: per-channel 1-D max pooling over windows of POOL valid vectors,
// stride POOL, with frames of SEQ_LEN vectors. A short trailing window at the
// end of a frame is emitted on its own; windows never straddle frames.
//   clk        clock
//   rst        asynchronous active-low reset
//   vld_in     data_in carries a valid vector (no backpressure)
//   data_in    NO_CH signed samples of BW bits
//   vld_out    one-cycle strobe, one cycle after a window closes
//   data_out   pooled vector, held until the next vld_out
//   frame_end  with vld_out, marks the last pooled vector of a frame
module maxpool_fp
  import cnn_pkg::*;
#(
  parameter int NO_CH   = 10,
  parameter int BW      = 12,
  parameter int POOL    = 2,
  parameter int SEQ_LEN = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vld_in,
  input  logic [NO_CH-1:0][BW-1:0]  data_in,
  output logic                      vld_out,
  output logic [NO_CH-1:0][BW-1:0]  data_out,
  output logic                      frame_end
);

  localparam int WIN_W = cnt_w(POOL);
  localparam int FRM_W = cnt_w(SEQ_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(POOL - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(SEQ_LEN - 1);

  generate
    if (POOL < POOL_MIN || POOL > POOL_MAX ||
        SEQ_LEN < POOL || SEQ_LEN > SEQ_LEN_MAX) begin : g_bad_params
      $error("maxpool_fp: illegal POOL/SEQ_LEN");
    end
  endgenerate

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             vld_out_q, vld_out_d;
  logic             frame_end_q, frame_end_d;

  logic win_first;
  logic frame_last;
  logic win_close;

  assign win_first  = (win_cnt_q == '0);
  assign frame_last = (frame_cnt_q == FRM_LAST);
  // The frame boundary also closes the window, giving the partial window.
  assign win_close  = (win_cnt_q == WIN_LAST) || frame_last;

  always_comb begin
    win_cnt_d   = win_cnt_q;
    frame_cnt_d = frame_cnt_q;
    vld_out_d   = 1'b0;
    frame_end_d = 1'b0;
    if (vld_in) begin
      win_cnt_d   = win_close  ? '0 : win_cnt_q + 1'b1;
      frame_cnt_d = frame_last ? '0 : frame_cnt_q + 1'b1;
      vld_out_d   = win_close;
      frame_end_d = frame_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt_q   <= '0;
      frame_cnt_q <= '0;
      vld_out_q   <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      win_cnt_q   <= win_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      vld_out_q   <= vld_out_d;
      frame_end_q <= frame_end_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NO_CH; gi++) begin : g_lane
      max_lane #(
        .BW(BW)
      ) u_lane (
        .clk    (clk),
        .rst_n  (rst),
        .en_i   (vld_in),
        .first_i(win_first),
        .close_i(win_close),
        .data_i (data_in[gi]),
        .data_o (data_out[gi])
      );
    end
  endgenerate

  assign vld_out   = vld_out_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_maxpool_fp.sv
// tb_maxpool_fp: directed and randomized checks of maxpool_fp with
// NO_CH=2, BW=12, POOL=2, SEQ_LEN=5.
module tb_maxpool_fp;

  localparam int NO_CH   = 2;
  localparam int BW      = 12;
  localparam int POOL    = 2;
  localparam int SEQ_LEN = 5;

  logic                     clk;
  logic                     rst;
  logic                     vld_in;
  logic [NO_CH-1:0][BW-1:0] data_in;
  logic                     vld_out;
  logic [NO_CH-1:0][BW-1:0] data_out;
  logic                     frame_end;

  int errors = 0;
  int checks = 0;

  maxpool_fp #(
    .NO_CH  (NO_CH),
    .BW     (BW),
    .POOL   (POOL),
    .SEQ_LEN(SEQ_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (vld_in),
    .data_in  (data_in),
    .vld_out  (vld_out),
    .data_out (data_out),
    .frame_end(frame_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs read right after a drive
  // reflect the vector driven by the previous call.
  task automatic drive(input logic v, input int a, input int b);
    @(negedge clk);
    vld_in     = v;
    data_in[0] = a[BW-1:0];
    data_in[1] = b[BW-1:0];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b0;
    vld_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    vld_in  = 1'b0;
    data_in = '0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (vld_out !== 1'b0 || frame_end !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_async: vld_out=%b frame_end=%b data_out=%h required 0 0 0",
               vld_out, frame_end, data_out);
    end
    $display("test_reset: async clear checked");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] e0, e1;
    do_reset();
    drive(1, 5, -3);
    drive(1, 2, 7);
    drive(0, 0, 0);
    e0 = 12'd5; e1 = 12'd7;
    checks++;
    if (vld_out !== 1'b1 || frame_end !== 1'b0 || data_out[0] !== e0 || data_out[1] !== e1) begin
      errors++;
      $display("FAIL b2b_out: vld=%b fe=%b out={%0d,%0d} required 1 0 {5,7}",
               vld_out, frame_end, $signed(data_out[0]), $signed(data_out[1]));
    end
    drive(0, 0, 0);
    checks++;
    if (vld_out !== 1'b0 || data_out[0] !== e0 || data_out[1] !== e1) begin
      errors++;
      $display("FAIL b2b_hold: vld=%b out={%0d,%0d} required 0 {5,7}",
               vld_out, $signed(data_out[0]), $signed(data_out[1]));
    end
    $display("test_back_to_back: {5,-3},{2,7} -> {5,7}");
  endtask

  task automatic test_signed();
    logic [BW-1:0] e0, e1;
    drive(1, -8, -1);
    drive(1, -2, -4);
    checks++;
    if (vld_out !== 1'b0) begin
      errors++;
      $display("FAIL signed_mid: vld=%b required 0", vld_out);
    end
    drive(0, 0, 0);
    e0 = 12'hFFE; e1 = 12'hFFF;
    checks++;
    if (vld_out !== 1'b1 || frame_end !== 1'b0 || data_out[0] !== e0 || data_out[1] !== e1) begin
      errors++;
      $display("FAIL signed_out: vld=%b fe=%b out={%0d,%0d} required 1 0 {-2,-1}",
               vld_out, frame_end, $signed(data_out[0]), $signed(data_out[1]));
    end
    $display("test_signed: {-8,-1},{-2,-4} -> {-2,-1}");
  endtask

  task automatic test_frame();
    logic [BW-1:0] e0, e1;
    drive(1, 3, -9);          // vector 5: last of frame, window of one
    drive(0, 0, 0);
    e0 = 12'd3; e1 = 12'hFF7;
    checks++;
    if (vld_out !== 1'b1 || frame_end !== 1'b1 || data_out[0] !== e0 || data_out[1] !== e1) begin
      errors++;
      $display("FAIL frame_partial: vld=%b fe=%b out={%0d,%0d} required 1 1 {3,-9}",
               vld_out, frame_end, $signed(data_out[0]), $signed(data_out[1]));
    end
    drive(1, -5, -6);
    drive(1, -7, 1);
    checks++;
    if (vld_out !== 1'b0 || frame_end !== 1'b0) begin
      errors++;
      $display("FAIL frame_newwin_mid: vld=%b fe=%b required 0 0", vld_out, frame_end);
    end
    drive(0, 0, 0);
    e0 = 12'hFFB; e1 = 12'd1;
    checks++;
    if (vld_out !== 1'b1 || frame_end !== 1'b0 || data_out[0] !== e0 || data_out[1] !== e1) begin
      errors++;
      $display("FAIL frame_newwin: vld=%b fe=%b out={%0d,%0d} required 1 0 {-5,1}",
               vld_out, frame_end, $signed(data_out[0]), $signed(data_out[1]));
    end
    $display("test_frame: partial window and fresh window in next frame");
  endtask

  task automatic test_gaps();
    int va[4]  = '{1, 3, -1, 6};
    int vb[4]  = '{2, -4, 9, 0};
    int gap[4] = '{0, 1, 2, 3};
    logic [BW-1:0] w0[2];
    logic [BW-1:0] w1[2];
    logic          exp_v;
    int            win;
    w0[0] = 12'd3; w1[0] = 12'd2;
    w0[1] = 12'd6; w1[1] = 12'd9;
    do_reset();
    win = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1, va[k], vb[k]);
      exp_v = (k % 2 == 1);
      for (int g = 0; g <= gap[k]; g++) begin
        if (g == gap[k] && k < 3) drive(1, va[k+1], vb[k+1]);
        else drive(0, 0, 0);
        checks++;
        if (vld_out !== exp_v) begin
          errors++;
          $display("FAIL gaps_vld: vec=%0d idle=%0d vld=%b required %b", k, g, vld_out, exp_v);
        end
        if (exp_v) begin
          checks++;
          if (data_out[0] !== w0[win] || data_out[1] !== w1[win]) begin
            errors++;
            $display("FAIL gaps_data: win=%0d out={%0d,%0d} required {%0d,%0d}", win,
                     $signed(data_out[0]), $signed(data_out[1]),
                     $signed(w0[win]), $signed(w1[win]));
          end
          win++;
        end
        exp_v = 1'b0;
        if (g == gap[k] && k < 3) begin
          k++;
          exp_v = (k % 2 == 1);
          g = -1;  // restart idle loop for the vector just driven
        end
      end
    end
    $display("test_gaps: idle gaps 0..3, windows {3,2} and {6,9}");
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] e0, e1;
    do_reset();
    drive(1, 40, 40);
    @(posedge clk);
    #2;
    rst    = 1'b0;
    vld_in = 1'b0;
    #1;
    checks++;
    if (vld_out !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL rstmid_async: vld=%b out=%h required 0 0", vld_out, data_out);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, -2);
    drive(1, -3, 5);
    checks++;
    if (vld_out !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_stale: vld=%b required 0", vld_out);
    end
    drive(0, 0, 0);
    e0 = 12'd1; e1 = 12'd5;
    checks++;
    if (vld_out !== 1'b1 || data_out[0] !== e0 || data_out[1] !== e1) begin
      errors++;
      $display("FAIL rstmid_out: vld=%b out={%0d,%0d} required 1 {1,5}",
               vld_out, $signed(data_out[0]), $signed(data_out[1]));
    end
    $display("test_reset_mid: open window discarded, new window {1,5}");
  endtask

  task automatic test_random();
    int            mwin, mframe, macc0, macc1;
    logic          ev, efe;
    logic [BW-1:0] ed0, ed1;
    int            a, b, errs_before;
    logic          v;
    do_reset();
    mwin = 0; mframe = 0; macc0 = 0; macc1 = 0;
    ev = 1'b0; efe = 1'b0; ed0 = '0; ed1 = '0;
    errs_before = errors;
    for (int n = 0; n < 10000; n++) begin
      v = ($urandom_range(0, 9) < 6);
      a = int'($urandom_range(0, 4095)) - 2048;
      b = int'($urandom_range(0, 4095)) - 2048;
      drive(v, a, b);
      checks++;
      if (vld_out !== ev || frame_end !== efe || data_out[0] !== ed0 || data_out[1] !== ed1) begin
        errors++;
        $display("FAIL random: cyc=%0d vld=%b fe=%b out={%0d,%0d} required %b %b {%0d,%0d}",
                 n, vld_out, frame_end, $signed(data_out[0]), $signed(data_out[1]),
                 ev, efe, $signed(ed0), $signed(ed1));
      end
      ev = 1'b0; efe = 1'b0;
      if (v) begin
        if (mwin == 0) begin
          macc0 = a; macc1 = b;
        end else begin
          if (a > macc0) macc0 = a;
          if (b > macc1) macc1 = b;
        end
        if (mwin == POOL - 1 || mframe == SEQ_LEN - 1) begin
          ev  = 1'b1;
          efe = (mframe == SEQ_LEN - 1);
          ed0 = macc0[BW-1:0];
          ed1 = macc1[BW-1:0];
          mwin = 0;
        end else begin
          mwin++;
        end
        mframe = (mframe == SEQ_LEN - 1) ? 0 : mframe + 1;
      end
    end
    $display("test_random: 10000 cycles, %0d mismatches", errors - errs_before);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_signed();
    test_frame();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
